// File: rtl/adc_scan_sequencer_if.sv
// Conversion handshake between the scan sequencer and the ADC front-end.
//   conv_req  : sequencer -> front-end, held high until ack or timeout
//   conv_ch   : sequencer -> front-end, channel for the pending request
//   conv_ack  : front-end -> sequencer, one-cycle completion strobe
//   conv_data : front-end -> sequencer, result qualified by conv_ack
interface adc_scan_sequencer_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned CH_W   = 3
) ();
    logic              conv_req;
    logic [CH_W-1:0]   conv_ch;
    logic              conv_ack;
    logic [DATA_W-1:0] conv_data;

    modport master (
        output conv_req,
        output conv_ch,
        input  conv_ack,
        input  conv_data
    );

    modport slave (
        input  conv_req,
        input  conv_ch,
        output conv_ack,
        output conv_data
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Scans the external ADC front-end one channel at a time, single-shot or
// continuous with an inter-frame gap, with a per-conversion timeout.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   enable, start      : run gate and one-cycle start pulse
//   num_ch             : channels per frame (0 or > N_CH means N_CH)
//   continuous, period : re-scan mode and gap length in cycles
//   err_clr            : clears the sticky timeout flag
//   conv               : front-end request/acknowledge handshake (master)
//   sample_*           : per-channel result strobe, channel and data
//   frame_done/count   : end-of-frame pulse and wrapping frame counter
//   busy, timeout_err  : not-idle status and sticky timeout flag
module adc_scan_sequencer #(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                enable,
    input  logic                start,
    input  logic [3:0]          num_ch,
    input  logic                continuous,
    input  logic [PERIOD_W-1:0] period,
    input  logic                err_clr,
    adc_scan_sequencer_if.master conv,
    output logic                sample_valid,
    output logic [2:0]          sample_ch,
    output logic [DATA_W-1:0]   sample_data,
    output logic                frame_done,
    output logic [15:0]         frame_count,
    output logic                busy,
    output logic                timeout_err
);
    localparam int unsigned CH_W  = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned FC_W  = 16;
    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        STORE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    eff_ch;
    logic [CH_W-1:0]     ch;
    logic [TO_W-1:0]     tcnt;
    logic [PERIOD_W-1:0] gap_cnt;
    logic                last_ch_c;

    // Out-of-range channel counts fall back to a full scan.
    function automatic logic [CNT_W-1:0] eff_of(input logic [3:0] n);
        if (n == 4'd0 || 32'(n) > N_CH) return CNT_W'(N_CH);
        return CNT_W'(n);
    endfunction

    assign last_ch_c = (CNT_W'(ch) == eff_ch - CNT_W'(1));

    // Scan FSM; every output is a register updated alongside the state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            eff_ch         <= '0;
            ch             <= '0;
            tcnt           <= '0;
            gap_cnt        <= '0;
            conv.conv_req  <= 1'b0;
            conv.conv_ch   <= '0;
            sample_valid   <= 1'b0;
            sample_ch      <= '0;
            sample_data    <= '0;
            frame_done     <= 1'b0;
            frame_count    <= '0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            // A timeout later in this block overrides the clear.
            if (err_clr) timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && enable) begin
                        state         <= CONV;
                        eff_ch        <= eff_of(num_ch);
                        ch            <= '0;
                        tcnt          <= '0;
                        conv.conv_req <= 1'b1;
                        conv.conv_ch  <= '0;
                        busy          <= 1'b1;
                    end
                end

                CONV: begin
                    // Ack wins over an expiring timeout in the same cycle.
                    if (conv.conv_ack || tcnt == TO_W'(TIMEOUT - 1)) begin
                        state         <= STORE;
                        conv.conv_req <= 1'b0;
                        sample_ch     <= ch;
                        if (conv.conv_ack) begin
                            sample_valid <= 1'b1;
                            sample_data  <= conv.conv_data;
                        end else begin
                            timeout_err  <= 1'b1;
                        end
                        if (last_ch_c) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + FC_W'(1);
                        end
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end

                STORE: begin
                    tcnt <= '0;
                    if (last_ch_c) begin
                        if (continuous && enable && period != '0) begin
                            state   <= GAP;
                            gap_cnt <= period;
                        end else if (continuous && enable) begin
                            state         <= CONV;
                            eff_ch        <= eff_of(num_ch);
                            ch            <= '0;
                            conv.conv_req <= 1'b1;
                            conv.conv_ch  <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (enable) begin
                        state         <= CONV;
                        ch            <= ch + CH_W'(1);
                        conv.conv_req <= 1'b1;
                        conv.conv_ch  <= ch + CH_W'(1);
                    end else begin
                        // Aborted frame: no frame_done, count untouched.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                GAP: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gap_cnt == PERIOD_W'(1)) begin
                        state         <= CONV;
                        eff_ch        <= eff_of(num_ch);
                        ch            <= '0;
                        tcnt          <= '0;
                        conv.conv_req <= 1'b1;
                        conv.conv_ch  <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - PERIOD_W'(1);
                    end
                end

                default: begin
                    state         <= IDLE;
                    conv.conv_req <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: a front-end model answers requests
// with a programmable latency, stimulus pushes expected samples and frames
// into queues, and a monitor pops and compares on every DUT strobe.
module tb_adc_scan_sequencer;
    localparam int unsigned DATA_W = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  num_ch = 4'd0;
    logic        continuous = 1'b0;
    logic [15:0] period = 16'd0;
    logic        err_clr = 1'b0;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [23:0] sample_data;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        busy;
    logic        timeout_err;

    adc_scan_sequencer_if #(.DATA_W(DATA_W), .CH_W(3)) conv_if ();

    adc_scan_sequencer #(
        .N_CH(8), .DATA_W(DATA_W), .PERIOD_W(16), .TIMEOUT(255)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .enable       (enable),
        .start        (start),
        .num_ch       (num_ch),
        .continuous   (continuous),
        .period       (period),
        .err_clr      (err_clr),
        .conv         (conv_if.master),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .frame_done   (frame_done),
        .frame_count  (frame_count),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ch;
        logic [23:0] data;
    } samp_t;

    typedef struct {
        logic [15:0] fc;
        int          ch;   // -1: last channel timed out, sample_ch not checked
    } frm_t;

    samp_t samp_q[$];
    frm_t  frm_q[$];

    int checks = 0;
    int errors = 0;

    // Front-end model controls
    int ack_lat   = 0;
    int drop_ch   = -1;
    int data_base = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h required %0h", nm, act, exp_v);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired", nm);
    endtask

    task automatic push_samp(input int c, input int d);
        samp_t s;
        s.ch   = 3'(c);
        s.data = 24'(d);
        samp_q.push_back(s);
    endtask

    task automatic push_frm(input int fc, input int c);
        frm_t f;
        f.fc = 16'(fc);
        f.ch = c;
        frm_q.push_back(f);
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout_fail(nm);
    endtask

    task automatic wait_frame_done(input string nm);
        int n = 0;
        while (!frame_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done) timeout_fail(nm);
    endtask

    task automatic wait_req_ch(input string nm, input int c);
        int n = 0;
        while (!(conv_if.conv_req && int'(conv_if.conv_ch) == c) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!(conv_if.conv_req && int'(conv_if.conv_ch) == c)) timeout_fail(nm);
    endtask

    // Front-end model: acks ack_lat cycles after a request is first seen.
    initial begin
        int  wcnt;
        bit  sent;
        wcnt = 0;
        sent = 1'b0;
        conv_if.conv_ack  = 1'b0;
        conv_if.conv_data = '0;
        forever begin
            @(negedge clk);
            conv_if.conv_ack = 1'b0;
            if (!conv_if.conv_req) begin
                wcnt = 0;
                sent = 1'b0;
            end else if (!sent && int'(conv_if.conv_ch) != drop_ch) begin
                if (wcnt == ack_lat) begin
                    conv_if.conv_ack  = 1'b1;
                    conv_if.conv_data = 24'(data_base + int'(conv_if.conv_ch));
                    sent = 1'b1;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Monitor: compares every sample and frame strobe against the queues.
    initial begin
        samp_t s;
        frm_t  f;
        forever begin
            @(negedge clk);
            if (sample_valid) begin
                if (samp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sample_unexpected got ch=%0d data=%0h required no sample", sample_ch, sample_data);
                end else begin
                    s = samp_q.pop_front();
                    check("sample_ch", 64'(sample_ch), 64'(s.ch));
                    check("sample_data", 64'(sample_data), 64'(s.data));
                end
            end
            if (frame_done) begin
                if (frm_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected got frame_count=%0d required no frame_done", frame_count);
                end else begin
                    f = frm_q.pop_front();
                    check("frame_count", 64'(frame_count), 64'(f.fc));
                    if (f.ch >= 0) check("frame_last_ch", 64'(sample_ch), 64'(f.ch));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_conv_req", 64'(conv_if.conv_req), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_frame_count", 64'(frame_count), 64'(0));
        check("rst_timeout_err", 64'(timeout_err), 64'(0));
        check("rst_strobes", 64'({sample_valid, frame_done}), 64'(0));

        // start ignored while disabled
        do_start();
        check("start_disabled", 64'(busy), 64'(0));

        // Single-shot, 4 channels, ack 3 cycles after request
        enable = 1'b1; num_ch = 4'd4; continuous = 1'b0;
        ack_lat = 3; data_base = 'h100;
        for (int i = 0; i < 4; i++) push_samp(i, 'h100 + i);
        push_frm(1, 3);
        do_start();
        check("t1_first_req", 64'({conv_if.conv_req, conv_if.conv_ch}), 64'({1'b1, 3'd0}));
        wait_idle("t1_idle", 200);
        check("t1_frame_count", 64'(frame_count), 64'(1));

        // Zero-latency ack, num_ch=0 -> 8 channels in 16 cycles
        num_ch = 4'd0; ack_lat = 0; data_base = 'h200;
        for (int i = 0; i < 8; i++) push_samp(i, 'h200 + i);
        push_frm(2, 7);
        do_start();
        cnt = 1;
        while (!frame_done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("t2_frame_len", 64'(cnt), 64'(16));
        wait_idle("t2_idle", 50);

        // Timeout on the last channel, with err_clr held across the timeout edge
        num_ch = 4'd3; drop_ch = 2; ack_lat = 1; data_base = 'h300;
        push_samp(0, 'h300);
        push_samp(1, 'h301);
        push_frm(3, -1);
        err_clr = 1'b1;
        do_start();
        wait_req_ch("t3_req_ch2", 2);
        cnt = 1;
        while (conv_if.conv_req && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        cnt--;
        err_clr = 1'b0;
        check("t3_timeout_len", 64'(cnt), 64'(255));
        wait_idle("t3_idle", 50);
        check("t3_err_set_wins", 64'(timeout_err), 64'(1));
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        check("t3_err_clr", 64'(timeout_err), 64'(0));
        drop_ch = -1;

        // Ack on the final permitted cycle beats the timeout
        num_ch = 4'd1; ack_lat = 254; data_base = 'h350;
        push_samp(0, 'h350);
        push_frm(4, 0);
        do_start();
        wait_idle("t3b_idle", 400);
        check("t3b_ack_wins", 64'(timeout_err), 64'(0));

        // Continuous, period=10, num_ch=2
        num_ch = 4'd2; continuous = 1'b1; period = 16'd10;
        ack_lat = 0; data_base = 'h400;
        for (int f = 0; f < 2; f++) begin
            push_samp(0, 'h400);
            push_samp(1, 'h401);
        end
        push_frm(5, 1);
        push_frm(6, 1);
        do_start();
        wait_frame_done("t4_frame1");
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            if (conv_if.conv_req) break;
            cnt++;
        end
        check("t4_gap_len", 64'(cnt), 64'(10));
        check("t4_gap_ch0", 64'(conv_if.conv_ch), 64'(0));
        wait_frame_done("t4_frame2");
        @(negedge clk) enable = 1'b0;
        @(negedge clk);
        check("t4_gap_abort", 64'({busy, conv_if.conv_req}), 64'(0));
        check("t4_frame_count", 64'(frame_count), 64'(6));
        continuous = 1'b0; period = 16'd0;

        // Enable dropped mid-CONV on ch1; start while busy has no effect
        enable = 1'b1; num_ch = 4'd4; ack_lat = 3; data_base = 'h500;
        push_samp(0, 'h500);
        push_samp(1, 'h501);
        do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("t5_busy_start", 64'({conv_if.conv_req, conv_if.conv_ch}), 64'({1'b1, 3'd0}));
        wait_req_ch("t5_req_ch1", 1);
        enable = 1'b0;
        cnt = 1;
        while (conv_if.conv_req && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        cnt--;
        check("t5_req_held", 64'(cnt), 64'(4));
        wait_idle("t5_idle", 20);
        repeat (3) @(negedge clk);
        check("t5_stays_idle", 64'(busy), 64'(0));
        check("t5_frame_count", 64'(frame_count), 64'(6));

        // Reset mid-CONV, then a fresh single-channel scan
        enable = 1'b1; num_ch = 4'd4; ack_lat = 3; data_base = 'h600;
        push_samp(0, 'h600);
        do_start();
        wait_req_ch("t6_req_ch1", 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_req", 64'(conv_if.conv_req), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_fc", 64'(frame_count), 64'(0));
        rst = 1'b0;
        num_ch = 4'd1; data_base = 'h610;
        push_samp(0, 'h610);
        push_frm(1, 0);
        do_start();
        check("t6_restart_ch0", 64'({conv_if.conv_req, conv_if.conv_ch}), 64'({1'b1, 3'd0}));
        wait_idle("t6_idle", 50);
        check("t6_frame_count", 64'(frame_count), 64'(1));

        repeat (4) @(negedge clk);
        check("sb_samples_left", 64'(samp_q.size()), 64'(0));
        check("sb_frames_left", 64'(frm_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Sequences the external ADC front-end across channels, one conversion at a time.
- Triggered by the CTRL.START pulse; gated by CTRL.ENABLE. Channel count comes from ADC_CFG.NUM_CH.
- Delivers per-channel results to the ADC_RAW register file and frame events to the events block.
- Supports single-shot and continuous (periodic) scanning, with per-conversion timeout protection.

Parameters:
- N_CH, 8, maximum number of channels.
- DATA_W, 24, ADC result width.
- PERIOD_W, 16, width of the inter-frame gap counter.
- TIMEOUT, 255, maximum cycles conv_req is held without conv_ack (must be ≥1).

Ports:
- wb_clk_i  in  1  clock, single domain.
- wb_rst_i  in  1  synchronous, active-high reset.
- enable  in  1  level; from ctrl_enable.
- start  in  1  one-cycle pulse; from ctrl_start.
- num_ch  in  4  channels per frame; from ADC_CFG.
- continuous  in  1  1 = re-scan after the gap; 0 = single frame.
- period  in  PERIOD_W  gap cycles between frames.
- err_clr  in  1  pulse; clears timeout_err.
- conv_req  out  1  conversion request to the front-end.
- conv_ch  out  3  channel index for the current request.
- conv_ack  in  1  one-cycle completion strobe from the front-end.
- conv_data  in  DATA_W  result; valid with conv_ack.
- sample_valid  out  1  one-cycle pulse; result written.
- sample_ch  out  3  channel of the sample.
- sample_data  out  DATA_W  latched result.
- frame_done  out  1  one-cycle pulse at the end of a full frame.
- frame_count  out  16  completed frames; wraps.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Clocking and reset:
  - One clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
  - Reset, including mid-frame, forces IDLE.
  - Reset values: all outputs 0; frame_count = 0; internal counters = 0.
- States: IDLE, CONV, STORE, GAP.
- IDLE:
  - start=1 with enable=1 at edge T → CONV at T+1, with conv_req=1 and conv_ch=0.
  - num_ch is latched at this point. Effective count: 0 or >N_CH → N_CH; otherwise num_ch.
  - start is ignored when enable=0.
  - start is ignored outside IDLE (no queuing).
- CONV:
  - conv_req=1 and conv_ch held stable for the whole state.
  - conv_ack sampled high → latch conv_data, go STORE.
  - A timeout counter counts CONV cycles. If TIMEOUT cycles elapse without ack → STORE with the timeout flag set, and timeout_err set.
  - Ack wins over timeout in the same cycle.
  - conv_ack outside CONV is ignored.
- STORE (exactly 1 cycle):
  - conv_req=0.
  - Normal completion: sample_valid=1, with sample_ch/sample_data valid for that cycle.
  - Timeout completion: sample_valid stays 0.
  - Last channel (ch == eff-1):
    - frame_done=1 and frame_count+1 (16-bit wrap), regardless of any timeouts in the frame.
    - Next state: GAP if continuous & enable & period≠0; CONV ch0 if continuous & enable & period=0; otherwise IDLE.
    - period is sampled here.
  - Not the last channel: enable=1 → CONV with ch+1; enable=0 → IDLE with no frame_done (aborted frame, frame_count unchanged).
- Timing:
  - Minimum per-channel cost is 2 cycles (ack in the first CONV cycle).
  - conv_req therefore always drops for ≥1 cycle between requests.
- GAP:
  - Lasts exactly `period` cycles, then CONV ch0. num_ch is re-latched.
  - enable=0 → IDLE at the next edge.
- Enable deassert during CONV:
  - The handshake is never broken. conv_req stays high until ack or timeout; then STORE, then IDLE.
- timeout_err:
  - Set on timeout; cleared by err_clr.
  - Set wins over a simultaneous err_clr.
- busy = (state != IDLE).

Test Plan:
1. Single-shot: num_ch=4, continuous=0, ack 3 cycles after each req, data = 0x100+ch → 4 sample_valid pulses with ch 0..3 and data 0x100..0x103; one frame_done; frame_count=1; busy falls after the last STORE.
2. Zero-latency ack, num_ch=0 → 8 channels; frame spans 16 cycles from the first conv_req; frame_done coincides with sample_ch=7.
3. Timeout: TIMEOUT=255, no ack on ch2 with num_ch=3 → conv_req high exactly 255 cycles on ch2; no sample for ch2; timeout_err=1; frame_done still fires; a later err_clr clears the flag.
4. Continuous, period=10, num_ch=2 → exactly 10 idle gap cycles between frame_done and the next conv_req (ch0); frame_count increments per frame; deasserting enable in GAP → IDLE next cycle.
5. enable dropped mid-CONV on ch1 → conv_req held until ack; sample for ch1 delivered; then IDLE; no frame_done; start pulses while busy produce no effect.
6. wb_rst_i asserted mid-CONV → next cycle conv_req=0, busy=0, frame_count=0; a subsequent start begins at ch0.
